// File: rtl/fp_classify_unit_if.sv
// Operand/result handshake bundle for fp_classify_unit.
// slave is the classifier side, master is the producer/consumer side.
interface fp_classify_unit_if #(
    parameter int TAG_W = 5
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [63:0]      INPUT_1;
    logic             SP_DP;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [63:0]      OUTPUT;
    logic [TAG_W-1:0] OUT_TAG;

    modport slave (
        input  IN_VALID, INPUT_1, SP_DP, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUTPUT, OUT_TAG
    );

    modport master (
        output IN_VALID, INPUT_1, SP_DP, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUTPUT, OUT_TAG
    );
endinterface

// File: rtl/fp_classify_unit.sv
// Two-stage valid/ready FP classifier: S1 decodes SP/DP fields, S2 produces
// the one-hot 10-bit class mask (fclass encoding), zero-extended to 64 bits.
module fp_classify_unit #(
    parameter int TAG_W = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FLUSH,
    fp_classify_unit_if.slave  bus
);

    typedef struct packed {
        logic sign;
        logic exp_ones;
        logic exp_zero;
        logic frac_zero;
        logic frac_msb;
    } fields_t;

    logic             s1_vld_q, s1_vld_d;
    fields_t          s1_f_q, s1_f_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_vld_q, s2_vld_d;
    logic [9:0]       s2_mask_q, s2_mask_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic    s2_load, in_ready, accept;
    fields_t dec;
    logic [9:0] mask;

    assign s2_load  = ~s2_vld_q | bus.OUT_READY;
    assign in_ready = ~RST & ~FLUSH & (~s1_vld_q | s2_load);
    assign accept   = bus.IN_VALID & in_ready;

    // An SP value not NaN-boxed in the upper word reads as canonical qNaN.
    always_comb begin
        dec = '0;
        if (bus.SP_DP) begin
            dec.sign      = bus.INPUT_1[63];
            dec.exp_ones  = &bus.INPUT_1[62:52];
            dec.exp_zero  = ~|bus.INPUT_1[62:52];
            dec.frac_zero = ~|bus.INPUT_1[51:0];
            dec.frac_msb  = bus.INPUT_1[51];
        end else if (!(&bus.INPUT_1[63:32])) begin
            dec.exp_ones  = 1'b1;
            dec.frac_msb  = 1'b1;
        end else begin
            dec.sign      = bus.INPUT_1[31];
            dec.exp_ones  = &bus.INPUT_1[30:23];
            dec.exp_zero  = ~|bus.INPUT_1[30:23];
            dec.frac_zero = ~|bus.INPUT_1[22:0];
            dec.frac_msb  = bus.INPUT_1[22];
        end
    end

    always_comb begin
        mask = '0;
        if (s1_f_q.exp_ones) begin
            if (s1_f_q.frac_zero)     mask[s1_f_q.sign ? 0 : 7] = 1'b1;
            else if (s1_f_q.frac_msb) mask[9] = 1'b1;
            else                      mask[8] = 1'b1;
        end else if (s1_f_q.exp_zero) begin
            if (s1_f_q.frac_zero)     mask[s1_f_q.sign ? 3 : 4] = 1'b1;
            else                      mask[s1_f_q.sign ? 2 : 5] = 1'b1;
        end else begin
            mask[s1_f_q.sign ? 1 : 6] = 1'b1;
        end
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_f_d    = s1_f_q;
        s1_tag_d  = s1_tag_q;
        s2_vld_d  = s2_vld_q;
        s2_mask_d = s2_mask_q;
        s2_tag_d  = s2_tag_q;

        if (accept) begin
            s1_f_d   = dec;
            s1_tag_d = bus.IN_TAG;
        end
        if (s2_load && s1_vld_q) begin
            s2_mask_d = mask;
            s2_tag_d  = s1_tag_q;
        end

        // FLUSH wins over both the accept and the S1->S2 transfer.
        if (FLUSH) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (accept)       s1_vld_d = 1'b1;
            else if (s2_load) s1_vld_d = 1'b0;
            if (s2_load)      s2_vld_d = s1_vld_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_vld_q  <= 1'b0;
            s1_f_q    <= '0;
            s1_tag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_mask_q <= '0;
            s2_tag_q  <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_f_q    <= s1_f_d;
            s1_tag_q  <= s1_tag_d;
            s2_vld_q  <= s2_vld_d;
            s2_mask_q <= s2_mask_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = s2_vld_q;
    assign bus.OUTPUT    = s2_vld_q ? {54'b0, s2_mask_q} : 64'h0;
    assign bus.OUT_TAG   = s2_tag_q;

endmodule

// File: tb/tb_fp_classify_unit.sv
// Directed bench for fp_classify_unit: class vectors, latency, backpressure,
// flush and asynchronous reset.
module tb_fp_classify_unit;
    localparam int TAG_W = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic FLUSH = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    fp_classify_unit_if #(.TAG_W(TAG_W)) bus ();

    fp_classify_unit #(.TAG_W(TAG_W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .FLUSH (FLUSH),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        bus.IN_VALID  = 1'b1;
        bus.INPUT_1   = 64'h3FF0000000000000;
        bus.SP_DP     = 1'b1;
        bus.IN_TAG    = 5'd3;
        bus.OUT_READY = 1'b1;
        cycle();
        n_vec++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.OUT_VALID); end
        n_vec++; if (bus.OUTPUT !== 64'h0) begin n_err++; $display("FAIL rst_output: got %h want 0", bus.OUTPUT); end
        n_vec++; if (bus.OUT_TAG !== 5'd0) begin n_err++; $display("FAIL rst_out_tag: got %0d want 0", bus.OUT_TAG); end
        n_vec++; if (bus.IN_READY !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", bus.IN_READY); end
        RST = 1'b0;
        #1;
        n_vec++; if (bus.IN_READY !== 1'b1) begin n_err++; $display("FAIL first_accept_ready: got %b want 1", bus.IN_READY); end
        cycle();
        bus.IN_VALID = 1'b0;
        cycle();
        n_vec++; if (bus.OUT_VALID !== 1'b1 || bus.OUTPUT !== 64'h40 || bus.OUT_TAG !== 5'd3) begin
            n_err++; $display("FAIL first_accept_result: got v=%b out=%h tag=%0d want v=1 out=40 tag=3",
                              bus.OUT_VALID, bus.OUTPUT, bus.OUT_TAG);
        end
        cycle();
    endtask

    task automatic test_latency();
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.INPUT_1   = 64'h3FF0000000000000;
        bus.SP_DP     = 1'b1;
        bus.IN_TAG    = 5'd7;
        cycle();
        bus.IN_VALID = 1'b0;
        n_vec++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL lat_early: got %b want 0", bus.OUT_VALID); end
        cycle();
        n_vec++; if (bus.OUT_VALID !== 1'b1 || bus.OUTPUT !== 64'h40 || bus.OUT_TAG !== 5'd7) begin
            n_err++; $display("FAIL lat_result: got v=%b out=%h tag=%0d want v=1 out=40 tag=7",
                              bus.OUT_VALID, bus.OUTPUT, bus.OUT_TAG);
        end
        cycle();
        n_vec++; if (bus.OUT_VALID !== 1'b0 || bus.OUTPUT !== 64'h0) begin
            n_err++; $display("FAIL lat_drain: got v=%b out=%h want v=0 out=0", bus.OUT_VALID, bus.OUTPUT);
        end
    endtask

    task automatic test_classes();
        logic [63:0] v [14];
        logic        dp[14];
        logic [9:0]  m [14];
        v  = '{64'h3FF0000000000000, 64'hFFFFFFFFFF800000, 64'h000000003F800000,
               64'h7FF0000000000001, 64'h8000000000000001, 64'h0000000000000000,
               64'hFFF0000000000000, 64'hFFF8000000000000, 64'hFFFFFFFF00000000,
               64'hFFFFFFFF80000000, 64'hFFFFFFFF00000001, 64'hFFFFFFFFBF800000,
               64'hFFFFFFFF7F800000, 64'hFFFFFFFF7F800001};
        dp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        m  = '{10'h040, 10'h001, 10'h200, 10'h100, 10'h004, 10'h010, 10'h001,
               10'h200, 10'h010, 10'h008, 10'h020, 10'h002, 10'h080, 10'h100};
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 14; i++) begin
            int k;
            bus.IN_VALID = 1'b1;
            bus.INPUT_1  = v[i];
            bus.SP_DP    = dp[i];
            bus.IN_TAG   = TAG_W'(i + 1);
            cycle();
            bus.IN_VALID = 1'b0;
            k = 0;
            while (bus.OUT_VALID !== 1'b1 && k < 8) begin
                cycle();
                k++;
            end
            n_vec++;
            if (bus.OUT_VALID !== 1'b1) begin
                n_err++; $display("FAIL class_%0d_timeout: got no result want out=%h", i, 64'(m[i]));
            end else if (bus.OUTPUT !== 64'(m[i]) || bus.OUT_TAG !== TAG_W'(i + 1)) begin
                n_err++; $display("FAIL class_%0d: got out=%h tag=%0d want out=%h tag=%0d",
                                  i, bus.OUTPUT, bus.OUT_TAG, 64'(m[i]), i + 1);
            end
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v[6];
        logic [9:0]  m[6];
        int sent, got;
        v = '{64'h3FF0000000000000, 64'h8000000000000001, 64'h0000000000000000,
              64'h7FF0000000000001, 64'hFFF0000000000000, 64'h7FF8000000000000};
        m = '{10'h040, 10'h004, 10'h010, 10'h100, 10'h001, 10'h200};
        sent = 0;
        got  = 0;
        bus.SP_DP = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bus.OUT_READY = (c >= 4);
            if (sent < 6) begin
                bus.IN_VALID = 1'b1;
                bus.INPUT_1  = v[sent];
                bus.IN_TAG   = TAG_W'(sent + 1);
            end else begin
                bus.IN_VALID = 1'b0;
            end
            #1;
            if (c == 2 || c == 3) begin
                n_vec++; if (bus.IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready_c%0d: got %b want 0", c, bus.IN_READY); end
                n_vec++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_TAG !== 5'd1 || bus.OUTPUT !== 64'h40) begin
                    n_err++; $display("FAIL bp_hold_c%0d: got v=%b tag=%0d out=%h want v=1 tag=1 out=40",
                                      c, bus.OUT_VALID, bus.OUT_TAG, bus.OUTPUT);
                end
            end
            if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
                n_vec++;
                if (got >= 6) begin
                    n_err++; $display("FAIL bp_extra: got tag=%0d want no result", bus.OUT_TAG);
                end else begin
                    if (bus.OUT_TAG !== TAG_W'(got + 1) || bus.OUTPUT !== 64'(m[got]) || c != 4 + got) begin
                        n_err++; $display("FAIL bp_order: got tag=%0d out=%h cycle=%0d want tag=%0d out=%h cycle=%0d",
                                          bus.OUT_TAG, bus.OUTPUT, c, got + 1, 64'(m[got]), 4 + got);
                    end
                    got++;
                end
            end
            if (bus.IN_VALID === 1'b1 && bus.IN_READY === 1'b1) sent++;
            cycle();
        end
        bus.IN_VALID = 1'b0;
        n_vec++; if (got != 6 || sent != 6) begin n_err++; $display("FAIL bp_count: got results=%0d sent=%0d want 6/6", got, sent); end
    endtask

    task automatic test_flush();
        logic seen;
        bus.OUT_READY = 1'b0;
        bus.SP_DP     = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.INPUT_1   = 64'h3FF0000000000000;
        bus.IN_TAG    = 5'd10;
        cycle();
        bus.IN_TAG    = 5'd11;
        cycle();
        FLUSH        = 1'b1;
        bus.IN_TAG   = 5'd12;
        #1;
        n_vec++; if (bus.IN_READY !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", bus.IN_READY); end
        n_vec++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_TAG !== 5'd10) begin
            n_err++; $display("FAIL flush_prefill: got v=%b tag=%0d want v=1 tag=10", bus.OUT_VALID, bus.OUT_TAG);
        end
        cycle();
        FLUSH        = 1'b0;
        bus.IN_VALID = 1'b0;
        #1;
        n_vec++; if (bus.OUT_VALID !== 1'b0 || bus.OUTPUT !== 64'h0) begin
            n_err++; $display("FAIL flush_clear: got v=%b out=%h want v=0 out=0", bus.OUT_VALID, bus.OUTPUT);
        end
        n_vec++; if (bus.IN_READY !== 1'b1) begin n_err++; $display("FAIL flush_ready_after: got %b want 1", bus.IN_READY); end
        bus.OUT_READY = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (bus.OUT_VALID !== 1'b0) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_result: got result after flush want none"); end
    endtask

    task automatic test_async_reset();
        logic seen;
        bus.OUT_READY = 1'b0;
        bus.SP_DP     = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.INPUT_1   = 64'h8000000000000001;
        bus.IN_TAG    = 5'd20;
        cycle();
        bus.IN_TAG    = 5'd21;
        cycle();
        bus.IN_VALID  = 1'b0;
        #1 RST = 1'b1;
        #1;
        n_vec++; if (bus.OUT_VALID !== 1'b0 || bus.OUTPUT !== 64'h0) begin
            n_err++; $display("FAIL arst_immediate: got v=%b out=%h want v=0 out=0", bus.OUT_VALID, bus.OUTPUT);
        end
        n_vec++; if (bus.OUT_TAG !== 5'd0 || bus.IN_READY !== 1'b0) begin
            n_err++; $display("FAIL arst_tag_ready: got tag=%0d rdy=%b want tag=0 rdy=0", bus.OUT_TAG, bus.IN_READY);
        end
        #1 RST = 1'b0;
        bus.OUT_READY = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (bus.OUT_VALID !== 1'b0) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL arst_stale: got stale result want none"); end
        bus.IN_VALID = 1'b1;
        bus.INPUT_1  = 64'h0;
        bus.IN_TAG   = 5'd22;
        cycle();
        bus.IN_VALID = 1'b0;
        cycle();
        n_vec++; if (bus.OUT_VALID !== 1'b1 || bus.OUTPUT !== 64'h10 || bus.OUT_TAG !== 5'd22) begin
            n_err++; $display("FAIL arst_recover: got v=%b out=%h tag=%0d want v=1 out=10 tag=22",
                              bus.OUT_VALID, bus.OUTPUT, bus.OUT_TAG);
        end
        cycle();
    endtask

    initial begin
        bus.IN_VALID  = 1'b0;
        bus.INPUT_1   = 64'h0;
        bus.SP_DP     = 1'b0;
        bus.IN_TAG    = '0;
        bus.OUT_READY = 1'b0;
        @(negedge CLK);
        test_reset();
        test_latency();
        test_classes();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_classify_unit.md
FP_CLASSIFY_UNIT -- requirements
Module: fp_classify_unit

Interface
REQ-001 The parameters SHALL be:
- TAG_W, default 5: width of the destination tag carried with each operand.
REQ-002 The ports SHALL be as follows (clock and reset first):
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- FLUSH  input  1  synchronous pipeline kill.
- IN_VALID  input  1  operand offered.
- IN_READY  output  1  operand accepted when IN_VALID & IN_READY.
- INPUT_1  input  64  operand register value.
- SP_DP  input  1  precision: 1 = double, 0 = single.
- IN_TAG  input  TAG_W  destination tag.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer accepts the result when OUT_VALID & OUT_READY.
- OUTPUT  output  64  class mask, zero-extended to 64 bits.
- OUT_TAG  output  TAG_W  tag of the result.

Function
REQ-003 The block SHALL be a two-stage valid/ready pipeline with stages S1 (field decode) and S2 (class mask); each stage holds one valid bit plus data registers.
REQ-004 S1 SHALL capture at acceptance:
- sign, exp_all_ones, exp_zero, frac_zero, frac_msb.
- SP fields from INPUT_1[31:0]: sign bit 31, exponent [30:23], fraction [22:0].
- DP fields: sign bit 63, exponent [62:52], fraction [51:0].
REQ-005 An SP operand whose INPUT_1[63:32] != 32'hFFFFFFFF (improperly NaN-boxed) SHALL be decoded as canonical quiet NaN.
REQ-006 S2 SHALL compute exactly one set bit of OUTPUT[9:0], with OUTPUT[63:10] = 0:
- bit 0 = -inf; bit 1 = -normal; bit 2 = -subnormal; bit 3 = -0.
- bit 4 = +0; bit 5 = +subnormal; bit 6 = +normal; bit 7 = +inf.
- bit 8 = signaling NaN (exp all ones, frac != 0, frac_msb = 0).
- bit 9 = quiet NaN (exp all ones, frac_msb = 1).
REQ-007 NaN classification SHALL ignore the sign bit.
REQ-008 Latency SHALL be 2 cycles: an operand accepted at edge N produces OUT_VALID = 1 after edge N+1, given no stall.
REQ-009 S2 SHALL hold OUTPUT, OUT_TAG and OUT_VALID stable while OUT_VALID & ~OUT_READY.
REQ-010 S2 SHALL load from S1 when S2 is empty or OUT_READY = 1; it SHALL become empty if S1 is empty at that edge.
REQ-011 IN_READY SHALL equal ~S1_valid | S2_load and SHALL NOT depend combinationally on IN_VALID.
REQ-012 With the pipeline full and OUT_READY = 1, the block SHALL sustain one accept and one result per cycle.
REQ-013 OUT_TAG SHALL travel with its operand; results SHALL leave in acceptance order with no drops or duplicates.
REQ-014 FLUSH = 1 SHALL clear both valid bits at the next edge, override any simultaneous accept, and drive IN_READY = 0 during that cycle.
REQ-015 Data registers MAY hold stale values while their stage valid bit is 0; OUTPUT SHALL nevertheless read 0 whenever OUT_VALID = 0.

Reset
REQ-016 RST = 1 SHALL immediately, without a clock, force:
- S1_valid = 0, S2_valid = 0, OUT_VALID = 0.
- OUTPUT = 64'h0, OUT_TAG = 0, all data registers 0.
REQ-017 While RST = 1, IN_READY SHALL be 0.
REQ-018 Operands in flight when RST rises mid-operation SHALL be discarded; no result appears after RST falls.
REQ-019 The first accept SHALL be possible on the first rising edge after RST deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- DP, INPUT_1 = 64'h3FF0000000000000, OUT_READY = 1 -> OUTPUT = 64'h40 exactly 2 cycles later, tag matched.
- SP, INPUT_1 = 64'hFFFFFFFFFF800000 -> OUTPUT = 64'h001; SP INPUT_1 = 64'h000000003F800000 (unboxed) -> OUTPUT = 64'h200.
- DP 64'h7FF0000000000001 -> 64'h100; DP 64'h8000000000000001 -> 64'h004; DP 64'h0000000000000000 -> 64'h010.
- Backpressure: stream tags 1..6 back-to-back with OUT_READY = 0 for 4 cycles. After 2 accepts IN_READY = 0 and OUTPUT/OUT_TAG hold at tag 1. After release, tags 1..6 emerge in order, one per cycle.
- FLUSH with both stages full plus a simultaneous IN_VALID -> next cycle OUT_VALID = 0; the offered operand is not accepted.
- RST pulsed asynchronously mid-stream between edges -> OUT_VALID = 0 and OUTPUT = 0 immediately; no stale result after release.
